// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and baud helper
package uart_pkg;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_t;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baudrate);
        return (clk_freq_hz + baudrate / 2) / baudrate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with a registered head output that reads 0 while empty
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
    logic [AW:0]      count, count_next;
    logic             do_pop, do_push;

    assign full  = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;

    // pop is served before push, so a full FIFO can accept a byte in the same cycle it is drained
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_next    = rd_ptr + AW'(do_pop);
        count_next = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    // storage array, written without reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    // pointers, occupancy and the look-ahead head register (bypasses the byte being written into the head slot)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd_next;
            count  <= count_next;
            head   <= count_next == '0 ? '0 : (do_push && rd_next == wr_ptr) ? data : mem[rd_next];
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with majority-vote sampling, receive FIFO and sticky errors
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUDRATE    = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    input  logic       rx_rd_strobe_i,
    input  logic       err_clear_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       framing_err_o,
    output logic       overrun_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUDRATE);
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] S1   = CW'(HALF);
    localparam logic [CW-1:0] S2   = CW'(HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_baud
        $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    rx_state_t     state;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          v0, v1, vote, at_vote;
    logic          push, full, empty;

    assign at_vote = cnt == S2;
    assign vote    = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);

    // two-flop synchronizer, reset to the idle level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_sync <= rx_meta;
        end
    end

    // receive FSM: bit timing, three-sample vote, deserialisation and the push pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= WAIT_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            v0      <= 1'b1;
            v1      <= 1'b1;
            push    <= 1'b0;
        end else begin
            push <= 1'b0;
            cnt  <= cnt == LAST ? '0 : cnt + CW'(1);
            if (cnt == S0) v0 <= rx_sync;
            if (cnt == S1) v1 <= rx_sync;
            case (state)
                WAIT_IDLE: if (rx_sync) state <= IDLE;
                IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) state <= START;
                end
                START: if (at_vote) begin
                    state   <= vote ? IDLE : DATA;
                    bit_idx <= '0;
                end
                DATA: if (at_vote) begin
                    shift   <= {vote, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= STOP;
                end
                STOP: if (at_vote) begin
                    push  <= vote;
                    state <= vote ? IDLE : WAIT_IDLE;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    // sticky error flags; a new error outranks a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            framing_err_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            framing_err_o <= (state == STOP && at_vote && !vote) | (framing_err_o & !err_clear_i);
            overrun_o     <= (push & full & !rx_rd_strobe_i) | (overrun_o & !err_clear_i);
        end
    end

    uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk_i),
        .rst  (rst_i),
        .push (push),
        .pop  (rx_rd_strobe_i),
        .data (shift),
        .full (full),
        .empty(empty),
        .head (rx_data_o)
    );

    assign rx_valid_o = !empty;

endmodule
